// File: rtl/muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers; result DATA_WIDTH+1 edges after start.
// Optional MTHI/MTLO write port enabled by defining MULDIV_HILO_WRITE_EN.
module muldiv #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] srcA,
  input  logic [DATA_WIDTH-1:0] srcB,
  input  logic [1:0]            op,
  input  logic                  start,
`ifdef MULDIV_HILO_WRITE_EN
  input  logic                  hilo_we,
  input  logic                  hilo_sel,
  input  logic [DATA_WIDTH-1:0] hilo_wdata,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  dz,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [1:0]      op_r;
  logic            sa;
  logic            sb;
  logic [W-1:0]    a_raw;
  logic [W-1:0]    b_mag;
  // Upper half: product high / partial remainder; lower half: multiplier / dividend-to-quotient.
  logic [2*W-1:0]  prod;

  logic [W-1:0]    a_mag_in;
  logic [W-1:0]    b_mag_in;
  logic [W:0]      mul_sum;
  logic [W:0]      div_shift;
  logic            div_ge;
  logic [W-1:0]    div_sub;
  logic [2*W-1:0]  prod_neg;
  logic [W-1:0]    q_fix;
  logic [W-1:0]    r_fix;

  always_comb begin
    a_mag_in  = (op[0] && srcA[W-1]) ? -srcA : srcA;
    b_mag_in  = (op[0] && srcB[W-1]) ? -srcB : srcB;
    mul_sum   = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, b_mag} : {(W+1){1'b0}});
    div_shift = prod[2*W-1:W-1];
    div_ge    = div_shift >= {1'b0, b_mag};
    // The remainder after a successful subtract is below the divisor, so W bits suffice.
    div_sub   = div_shift[W-1:0] - b_mag;
    prod_neg  = -prod;
    q_fix     = prod[W-1:0];
    r_fix     = prod[2*W-1:W];
    if (op_r[0] && (sa ^ sb)) q_fix = prod_neg[W-1:0];
    if (op_r[0] && sa)        r_fix = -prod[2*W-1:W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      op_r  <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      a_raw <= '0;
      b_mag <= '0;
      prod  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dz    <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      dz   <= 1'b0;
      case (state)
        IDLE: begin
`ifdef MULDIV_HILO_WRITE_EN
          if (hilo_we) begin
            if (hilo_sel) hi <= hilo_wdata;
            else          lo <= hilo_wdata;
          end
`endif
          if (start) begin
            op_r  <= op;
            sa    <= op[0] & srcA[W-1];
            sb    <= op[0] & srcB[W-1];
            a_raw <= srcA;
            b_mag <= b_mag_in;
            prod  <= {{W{1'b0}}, a_mag_in};
            cnt   <= CW'(W);
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          if (op_r[1]) begin
            if (div_ge) prod <= {div_sub, prod[W-2:0], 1'b1};
            else        prod <= {prod[2*W-2:0], 1'b0};
          end else begin
            prod <= {mul_sum, prod[W-1:1]};
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= SIGN;
        end
        SIGN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
          if (!op_r[1]) begin
            {hi, lo} <= (op_r[0] && (sa ^ sb)) ? prod_neg : prod;
          end else if (b_mag == '0) begin
            hi <= a_raw;
            lo <= '1;
            dz <= 1'b1;
          end else begin
            hi <= r_fix;
            lo <= q_fix;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: directed corner cases plus randomized operations vs. an arithmetic model.
module tb_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] srcA;
  logic [W-1:0] srcB;
  logic [1:0]   op;
  logic         start;
  logic         busy;
  logic         done;
  logic         dz;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
`ifdef MULDIV_HILO_WRITE_EN
  logic         hilo_we = 1'b0;
  logic         hilo_sel = 1'b0;
  logic [W-1:0] hilo_wdata = '0;
`endif

  int checks = 0;
  int failures = 0;

  muldiv #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .srcA(srcA), .srcB(srcB), .op(op), .start(start),
`ifdef MULDIV_HILO_WRITE_EN
    .hilo_we(hilo_we), .hilo_sel(hilo_sel), .hilo_wdata(hilo_wdata),
`endif
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns {dz, hi, lo} from plain arithmetic on the operands.
  function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
    logic signed [63:0] sa64;
    logic signed [63:0] sb64;
    logic [63:0] p;
    logic [31:0] q;
    logic [31:0] r;
    if (o == 2'd0) begin
      p = {32'd0, a} * {32'd0, b};
      return {1'b0, p};
    end
    if (o == 2'd1) begin
      sa64 = {{32{a[31]}}, a};
      sb64 = {{32{b[31]}}, b};
      p = sa64 * sb64;
      return {1'b0, p};
    end
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    if (o == 2'd2) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {1'b0, r, q};
  endfunction

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
    srcA  = a;
    srcB  = b;
    op    = o;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  // Waits for done, scrambling operand inputs meanwhile; n0 = edges already elapsed since the start edge.
  task automatic wait_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] o, input int n0);
    logic [64:0] m;
    int n;
    bit ok;
    m  = model(a, b, o);
    n  = n0;
    ok = 1'b1;
    while (!done && n < W + 10) begin
      if (!busy || dz) ok = 1'b0;
      srcA = $urandom;
      srcB = $urandom;
      op   = 2'($urandom_range(0, 3));
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(W + 1));
    check({tag, "_busy_during"}, {63'd0, ok}, 64'd1);
    check({tag, "_busy_in_done"}, {63'd0, busy}, 64'd0);
    check({tag, "_hi"}, {32'd0, hi}, {32'd0, m[63:32]});
    check({tag, "_lo"}, {32'd0, lo}, {32'd0, m[31:0]});
    check({tag, "_dz"}, {63'd0, dz}, {63'd0, m[64]});
  endtask

  logic [31:0] ta [8];
  logic [31:0] tb [8];
  logic [1:0]  to [8];

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  ro;
    bit seen;

    rst_n = 1'b0;
    start = 1'b0;
    srcA  = '0;
    srcB  = '0;
    op    = '0;
    tick();
    tick();
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_dz", {63'd0, dz}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    tick();

    ta[0] = 32'hFFFF_FFFF; tb[0] = 32'hFFFF_FFFF; to[0] = 2'd0;
    ta[1] = 32'hFFFF_FFFD; tb[1] = 32'h0000_0007; to[1] = 2'd1;
    ta[2] = 32'h8000_0000; tb[2] = 32'h8000_0000; to[2] = 2'd1;
    ta[3] = 32'd100;       tb[3] = 32'd7;         to[3] = 2'd2;
    ta[4] = 32'hFFFF_FFF9; tb[4] = 32'd2;         to[4] = 2'd3;
    ta[5] = 32'd7;         tb[5] = 32'hFFFF_FFFE; to[5] = 2'd3;
    ta[6] = 32'd5;         tb[6] = 32'd0;         to[6] = 2'd2;
    ta[7] = 32'h8000_0000; tb[7] = 32'hFFFF_FFFF; to[7] = 2'd3;
    for (int i = 0; i < 8; i++) begin
      launch(ta[i], tb[i], to[i]);
      wait_check($sformatf("dir%0d", i), ta[i], tb[i], to[i], 0);
      tick();
      check($sformatf("dir%0d_done_one_cycle", i), {62'd0, done, dz}, 64'd0);
    end

    // A start mid-operation must be dropped; a start in the done cycle must be taken.
    launch(32'd100, 32'd7, 2'd2);
    repeat (4) tick();
    srcA  = 32'd1;
    srcB  = 32'd1;
    op    = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_check("ignored_start", 32'd100, 32'd7, 2'd2, 5);
    launch(32'hFFFF_FFF9, 32'd2, 2'd3);
    wait_check("done_cycle_start", 32'hFFFF_FFF9, 32'd2, 2'd3, 0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        3: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      if (i % 2 == 1) begin
        tick();
        check("rand_idle_done", {62'd0, done, dz}, 64'd0);
      end
      launch(ra, rb, ro);
      wait_check($sformatf("rand%0d", i), ra, rb, ro, 0);
    end

    // Reset in the middle of an operation abandons it without a done pulse.
    tick();
    launch(32'h1234_5678, 32'h9ABC_DEF0, 2'd1);
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midreset_busy", {63'd0, busy}, 64'd0);
    check("midreset_hilo", {hi, lo}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < W + 10; i++) begin
      if (done) seen = 1'b1;
      tick();
    end
    check("midreset_no_done", {63'd0, seen}, 64'd0);

`ifdef MULDIV_HILO_WRITE_EN
    hilo_we    = 1'b1;
    hilo_sel   = 1'b1;
    hilo_wdata = 32'h1234_5678;
    tick();
    hilo_we = 1'b0;
    check("mthi_idle_hi", {32'd0, hi}, 64'h1234_5678);
    check("mthi_idle_lo", {32'd0, lo}, 64'd0);
    launch(32'd9, 32'd3, 2'd2);
    hilo_we    = 1'b1;
    hilo_wdata = 32'hDEAD_BEEF;
    tick();
    hilo_we = 1'b0;
    check("mthi_busy_hi", {32'd0, hi}, 64'h1234_5678);
    wait_check("after_mthi", 32'd9, 32'd3, 2'd2, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv.md
Name: muldiv

Overview:
Iterative multiply/divide unit in the EX stage, alongside alu. It takes the same srcA/srcB operands and performs MULT/MULTU/DIV/DIVU over multiple cycles. Results go into HI/LO registers, which feed the EX result mux for MFHI/MFLO. The pipeline control uses busy to stall issue of dependent instructions.

Parameters:
DATA_WIDTH, 32, operand and HI/LO width; must be even and >= 4

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  synchronous reset, active low
srcA  input  DATA_WIDTH  multiplicand / dividend
srcB  input  DATA_WIDTH  multiplier / divisor
op  input  2  operation: 0 MULTU, 1 MULT, 2 DIVU, 3 DIV
start  input  1  request; sampled only while busy=0
busy  output  1  operation in progress
done  output  1  one-cycle pulse; hi/lo hold the new result in this cycle
dz  output  1  divide-by-zero flag; valid only while done=1
hi  output  DATA_WIDTH  HI register (product high half / remainder)
lo  output  DATA_WIDTH  LO register (product low half / quotient)

Behaviour:
- Interface (already decided): one clock, clk. Reset is synchronous and active-low, named rst_n.
- Reset: at any edge with rst_n=0, go to IDLE and clear busy, done, dz, hi, lo and all internal registers to 0. This applies mid-operation too: the operation is abandoned and no done pulse is produced.
- FSM states: IDLE, CALC, SIGN.
- IDLE: start=1 at edge T latches srcA, srcB and op. It also latches the operand signs and magnitudes (magnitudes for signed ops, raw values for unsigned ops). Then go to CALC with the iteration counter at DATA_WIDTH.
- CALC: one iteration per cycle for exactly DATA_WIDTH cycles (edges T+1..T+DATA_WIDTH). Then go to SIGN.
- Multiply: shift-add on 2*DATA_WIDTH-bit unsigned magnitudes.
- Divide: restoring division. Each cycle produces one quotient bit using a DATA_WIDTH+1-bit trial subtract.
- SIGN (edge T+DATA_WIDTH+1): apply sign correction, write hi/lo, set done=1 for one cycle, return to IDLE.
- Signed multiply: negate the 2*DATA_WIDTH-bit product if the operand signs differ.
- Signed divide: negate the quotient if the signs differ. Negate the remainder if the dividend is negative (truncating semantics).
- busy=1 from edge T through edge T+DATA_WIDTH+1 (exclusive). busy=0 in the done cycle, so a new start is accepted in the done cycle.
- start while busy=1 is ignored; no queueing.
- srcA/srcB/op changes while busy are ignored, since the operands are latched.
- done is high in exactly one cycle per accepted start. Total latency is DATA_WIDTH+1 edges.
- Divide by zero (srcB=0, DIV or DIVU):
  - lo = all ones, hi = srcA as latched (unsigned pattern).
  - No sign correction is applied.
  - dz=1 in the done cycle; dz=0 in all other cycles and for multiplies.
- DIV of most-negative by -1: lo = most-negative value (wraps), hi = 0, dz=0.
- hi/lo hold their value except at SIGN (and the optional write path below).

Optional Feature:
MULDIV_HILO_WRITE_EN.
- Defined: adds these ports:
  - hilo_we  input  1
  - hilo_sel  input  1 (0=LO, 1=HI)
  - hilo_wdata  input  DATA_WIDTH
- These implement MTHI/MTLO. With hilo_we=1 and busy=0, the selected register takes hilo_wdata at the edge.
- hilo_we while busy=1 is ignored.
- hilo_we together with an accepted start: the write is applied, and the later result overwrites both registers.
- Undefined: the ports are absent; hi/lo are written only by SIGN and reset.

Test Plan:
1. MULTU 0xFFFFFFFF x 0xFFFFFFFF, start at edge T -> busy high T..T+32, done at T+33, hi=0xFFFFFFFE, lo=0x00000001, dz=0.
2. MULT 0xFFFFFFFD (-3) x 0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
3. DIVU 100/7 -> lo=0x0000000E, hi=0x00000002. DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7 / 0xFFFFFFFE (-2) -> lo=0xFFFFFFFD, hi=1.
4. DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, dz=1 for one cycle. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, dz=0.
5. Pulse start again at T+5 with different operands -> ignored, first result unchanged. Start in the done cycle -> accepted, next done 33 edges later. rst_n=0 at T+10 -> busy=0, hi=lo=0, no done ever.
6. (MULDIV_HILO_WRITE_EN) hilo_we=1, sel=1, wdata=0x12345678 while idle -> hi=0x12345678, lo unchanged. Same write while busy -> hi unchanged.
